// File: rtl/duart_rx_if.sv
// rtl/duart_rx_if.sv - receive byte handshake between duart_rx and its consumer
//
// Signals:
//   rxdata   8  FIFO head byte, meaningful while rxvalid=1
//   rxvalid  1  FIFO non-empty
//   rxready  1  consumer pop request; a pop happens when rxvalid & rxready
// Modports:
//   master  receiver side (drives rxdata/rxvalid)
//   slave   consumer side (drives rxready)

interface duart_rx_if;
    logic [7:0] rxdata;
    logic       rxvalid;
    logic       rxready;

    modport master (output rxdata, output rxvalid, input rxready);
    modport slave  (input rxdata, input rxvalid, output rxready);
endinterface

// File: rtl/duart_rx.sv
// rtl/duart_rx.sv - debug UART 8N1 receiver with ETU bit timing and receive FIFO
//
// Ports:
//   clk      sole clock
//   resetn   asynchronous active-low reset
//   rxd      serial line, asynchronous to clk, idle high
//   rxen     receiver enable; low aborts any frame and holds the FSM in IDLE
//   etu      bit period minus one in clk cycles (clamped to a minimum)
//   rx       duart_rx_if.master: rxdata / rxvalid / rxready byte handshake
//   busy     FSM not in IDLE
//   framerr  one-cycle pulse: stop bit sampled 0
//   overrun  one-cycle pulse: completed byte dropped because FIFO full
//   level    FIFO occupancy
//
// Build option: define DUART_RX_MAJORITY_EN for 2-of-3 majority sampling of
// each bit at H-1, H, H+1 (decision at H+1, etu minimum 4). Otherwise each
// bit is sampled once at H.

module duart_rx #(
    parameter int ETUW        = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          rxd,
    input  logic                          rxen,
    input  logic [ETUW-1:0]               etu,
    duart_rx_if.master                    rx,
    output logic                          busy,
    output logic                          framerr,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
`ifdef DUART_RX_MAJORITY_EN
    localparam logic [ETUW-1:0] ETU_MIN = ETUW'(4);
`else
    localparam logic [ETUW-1:0] ETU_MIN = ETUW'(3);
`endif

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // Line synchroniser and edge detect
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    logic                   rxs_prev;
    logic                   fall;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q   <= '1;
            rxs_prev <= 1'b1;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], rxd};
            rxs_prev <= rxs;
        end
    end

    assign rxs  = sync_q[SYNC_STAGES-1];
    assign fall = rxs_prev & ~rxs;

    // Bit timing
    state_t          state_q, state_d;
    logic [ETUW-1:0] etul;
    logic [ETUW-1:0] bitcnt;
    logic [ETUW-1:0] half;
    logic [2:0]      bidx;
    logic [7:0]      shift;
    logic            strobe;
    logic            bitval;
    logic            start_frame;
    logic            push_req;
    logic            ferr_d;

    assign half = etul >> 1;

`ifdef DUART_RX_MAJORITY_EN
    logic samp_a;
    logic samp_b;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            samp_a <= 1'b1;
            samp_b <= 1'b1;
        end else begin
            if (bitcnt == half - ETUW'(1)) samp_a <= rxs;
            if (bitcnt == half)            samp_b <= rxs;
        end
    end

    // Third vote is the live sample at H+1, where the decision is taken.
    assign strobe = (bitcnt == half + ETUW'(1));
    assign bitval = (samp_a & samp_b) | (samp_a & rxs) | (samp_b & rxs);
`else
    assign strobe = (bitcnt == half);
    assign bitval = rxs;
`endif

    // FSM
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        start_frame = 1'b0;
        push_req    = 1'b0;
        ferr_d      = 1'b0;
        if (!rxen) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fall) begin
                        start_frame = 1'b1;
                        state_d     = START;
                    end
                end
                START: begin
                    // A start bit that is high again at mid-bit was a glitch.
                    if (strobe) state_d = bitval ? IDLE : DATA;
                end
                DATA: begin
                    if (strobe && bidx == 3'd7) state_d = STOP;
                end
                STOP: begin
                    // Leaving mid stop bit lets a back-to-back start edge be caught.
                    if (strobe) begin
                        push_req = bitval;
                        ferr_d   = ~bitval;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign busy = (state_q != IDLE);

    // Counter and shift register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            etul   <= ETU_MIN;
            bitcnt <= '0;
            bidx   <= '0;
            shift  <= '0;
        end else begin
            if (start_frame) begin
                etul   <= (etu < ETU_MIN) ? ETU_MIN : etu;
                bitcnt <= '0;
                bidx   <= '0;
            end else if (state_q != IDLE) begin
                bitcnt <= (bitcnt == etul) ? '0 : bitcnt + ETUW'(1);
            end
            if (state_q == DATA && strobe) begin
                shift <= {bitval, shift[7:1]};
                bidx  <= bidx + 3'd1;
            end
        end
    end

    // Receive FIFO; head entry is read straight from the register array.
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          full;
    logic          pop;
    logic          wr;

    assign full       = (level == LW'(FIFO_DEPTH));
    assign rx.rxvalid = (level != '0);
    assign rx.rxdata  = mem[rptr];
    assign pop        = rx.rxvalid & rx.rxready;
    assign wr         = push_req & (~full | pop);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wptr    <= '0;
            rptr    <= '0;
            level   <= '0;
            framerr <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (wr) begin
                mem[wptr] <= shift;
                wptr      <= wptr + AW'(1);
            end
            if (pop) rptr <= rptr + AW'(1);
            level   <= level + LW'(wr) - LW'(pop);
            framerr <= ferr_d;
            overrun <= push_req & full & ~pop;
        end
    end

endmodule

// File: tb/tb_duart_rx.sv
// tb/tb_duart_rx.sv - scoreboard bench for duart_rx

module tb_duart_rx;

`ifdef DUART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        rxd = 1'b1;
    logic        rxen = 1'b0;
    logic [15:0] etu = 16'd15;
    logic        busy;
    logic        framerr;
    logic        overrun;
    logic [2:0]  level;

    duart_rx_if rxif ();

    duart_rx dut (
        .clk     (clk),
        .resetn  (resetn),
        .rxd     (rxd),
        .rxen    (rxen),
        .etu     (etu),
        .rx      (rxif),
        .busy    (busy),
        .framerr (framerr),
        .overrun (overrun),
        .level   (level)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         fe_base;
    int         ov_base;
    bit         saw_idle;
    logic [7:0] exp_q [$];
    logic [7:0] flip_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Monitor: pops against the scoreboard, counts pulses.
    always @(negedge clk) begin
        if (resetn) begin
            if (rxif.rxvalid && rxif.rxready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_pop: got %02h required none", rxif.rxdata);
                end else begin
                    chk("pop_data", rxif.rxdata, exp_q.pop_front());
                end
            end
            if (framerr) fe_cnt++;
            if (overrun) ov_cnt++;
            if (framerr && overrun) begin
                n_cmp++;
                n_bad++;
                $display("FAIL pulse_exclusive: got both required at most one");
            end
        end
    end

    // One 8N1 frame, one rxd update per clock. flip: data-bit offset inverted
    // for one cycle; abort_bit: frame bit at which rxen drops; pop_c: stop-bit
    // offset at which rxready is pulsed (others hold rxready low).
    task automatic send_frame(input logic [7:0] b, input int flip, input int stopv,
                              input int abort_bit, input int pop_c);
        int         p;
        logic [9:0] bits;
        p    = int'(etu) + 1;
        bits = {stopv[0], b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < p; c++) begin
                @(posedge clk);
                #1;
                rxd = bits[i] ^ ((i >= 1) && (i <= 8) && (c == flip));
                if (i == abort_bit && c == 0) rxen = 1'b0;
                if (pop_c >= 0) rxif.rxready = (i == 9) && (c == pop_c);
                if (i == 9 && !busy) saw_idle = 1'b1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rxd = 1'b1;
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got timeout required finish");
        $fatal(1, "timeout");
    end

    initial begin
        rxif.rxready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rxvalid", rxif.rxvalid, 0);
        chk("rst_level", level, 0);
        chk("rst_rxdata", rxif.rxdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_framerr", framerr, 0);
        chk("rst_overrun", overrun, 0);
        resetn = 1'b1;
        rxen   = 1'b1;
        idle(5);

        // Back-to-back 0x55, 0xA3 at P=16
        etu = 16'd15;
        rxif.rxready = 1'b1;
        fe_base = fe_cnt;
        ov_base = ov_cnt;
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hA3);
        saw_idle = 1'b0;
        send_frame(8'h55, -1, 1, -1, -1);
        chk("b2b_idle_in_stop", saw_idle, 1);
        send_frame(8'hA3, -1, 1, -1, -1);
        idle(8);
        wait_drain();
        chk("b2b_framerr", fe_cnt - fe_base, 0);
        chk("b2b_overrun", ov_cnt - ov_base, 0);

        // Framing error followed by a held-low break
        etu = 16'd7;
        fe_base = fe_cnt;
        send_frame(8'h3C, -1, 0, -1, -1);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            rxd = 1'b0;
        end
        chk("ferr_count", fe_cnt - fe_base, 1);
        chk("ferr_level", level, 0);
        chk("break_no_busy", busy, 0);
        idle(12);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, -1, 1, -1, -1);
        idle(6);
        wait_drain();
        chk("ferr_count_after", fe_cnt - fe_base, 1);

        // Overrun: five bytes into a four-entry FIFO
        rxif.rxready = 1'b0;
        ov_base = ov_cnt;
        for (int k = 1; k <= 5; k++) begin
            if (k <= 4) exp_q.push_back(8'(k));
            send_frame(8'(k), -1, 1, -1, -1);
        end
        idle(6);
        chk("ovr_level", level, 4);
        chk("ovr_count", ov_cnt - ov_base, 1);
        rxif.rxready = 1'b1;
        wait_drain();
        idle(3);
        chk("ovr_level_drained", level, 0);

        // Full FIFO with a pop on the push cycle of the fifth byte
        etu = 16'd15;
        rxif.rxready = 1'b0;
        ov_base = ov_cnt;
        for (int k = 0; k < 5; k++) exp_q.push_back(8'h11 + 8'(k));
        for (int k = 0; k < 4; k++) send_frame(8'h11 + 8'(k), -1, 1, -1, -1);
        send_frame(8'h15, -1, 1, -1, 7 + 3 + MAJ);
        idle(6);
        chk("full_pop_level", level, 4);
        chk("full_pop_overrun", ov_cnt - ov_base, 0);
        rxif.rxready = 1'b1;
        wait_drain();

        // Three-cycle low glitch
        fe_base = fe_cnt;
        idle(4);
        @(posedge clk);
        #1;
        rxd = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rxd = 1'b1;
        idle(40);
        chk("glitch_busy", busy, 0);
        chk("glitch_level", level, 0);
        chk("glitch_framerr", fe_cnt - fe_base, 0);

        // rxen drop during data bit 4 of 0x96, then 0x69
        send_frame(8'h96, -1, 1, 5, -1);
        idle(4);
        chk("abort_busy", busy, 0);
        chk("abort_framerr", fe_cnt - fe_base, 0);
        rxen = 1'b1;
        idle(8);
        exp_q.push_back(8'h69);
        send_frame(8'h69, -1, 1, -1, -1);
        idle(6);
        wait_drain();

        // One-cycle flip at the H sample of each data bit of 0x5A
        flip_exp = (MAJ != 0) ? 8'h5A : 8'hA5;
        exp_q.push_back(flip_exp);
        send_frame(8'h5A, 7 + 1, 1, -1, -1);
        idle(6);
        wait_drain();

        idle(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
